mastermind_engine: RTL and testbench

MASTERMIND_ENGINE -- requirements
Module: mastermind_engine

---
 rtl/mastermind_pkg.sv | 23 ++
 rtl/mastermind_peg_scorer.sv | 98 +++++++++
 rtl/mastermind_engine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mastermind_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared constants for the Mastermind touch-screen engine: colour field
// width, screen geometry, FSM state encoding and the solution LFSR.
package mastermind_pkg;

  localparam int COLOR_W  = 3;
  localparam int SCREEN_W = 480;
  localparam int SCREEN_H = 800;

  localparam logic [31:0] LFSR_SEED = 32'd35;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_SCORE = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_WON   = 3'd4;
  localparam logic [2:0] ST_LOST  = 3'd5;

  // Right-shifting Fibonacci LFSR, feedback taps at bits 0, 1, 2 and 12.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[0] ^ l[1] ^ l[2] ^ l[12], l[31:1]};
  endfunction

endpackage

// File: rtl/mastermind_peg_scorer.sv
// Multi-cycle peg scorer. A start pulse captures the guess and solution;
// the next cycle counts exact matches, then one cycle per colour adds the
// colour-overlap count. done is high in the last cycle, with black/white
// valid in that same cycle.
module mastermind_peg_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_COLS   = 4,
  parameter int NUM_COLORS = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [COLOR_W*NUM_COLS-1:0] guess_in,
  input  logic [COLOR_W*NUM_COLS-1:0] sol_in,
  output logic                        done,
  output logic [2:0]                  black,
  output logic [2:0]                  white
);

  localparam int GW = COLOR_W * NUM_COLS;
  localparam logic [2:0] LAST_STEP = 3'(NUM_COLORS);

  logic          busy_q, busy_d;
  logic [2:0]    step_q, step_d;
  logic [GW-1:0] guess_q, guess_d;
  logic [GW-1:0] sol_q, sol_d;
  logic [2:0]    black_q, black_d;
  logic [2:0]    total_q, total_d;

  logic [2:0]    match_cnt;
  logic [2:0]    cnt_guess, cnt_sol, color_min;
  logic [3:0]    total_sum;

  // Exact matches and the per-colour overlap for the colour named by step_q.
  always_comb begin
    match_cnt = '0;
    cnt_guess = '0;
    cnt_sol   = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (guess_q[COLOR_W*i +: COLOR_W] == sol_q[COLOR_W*i +: COLOR_W]) match_cnt = match_cnt + 3'd1;
      if (guess_q[COLOR_W*i +: COLOR_W] == step_q) cnt_guess = cnt_guess + 3'd1;
      if (sol_q[COLOR_W*i +: COLOR_W] == step_q) cnt_sol = cnt_sol + 3'd1;
    end
    color_min = (cnt_guess < cnt_sol) ? cnt_guess : cnt_sol;
    total_sum = {1'b0, total_q} + {1'b0, color_min};
  end

  // Step sequencing: capture on start, black on step 0, colours on 1..N.
  always_comb begin
    busy_d  = busy_q;
    step_d  = step_q;
    guess_d = guess_q;
    sol_d   = sol_q;
    black_d = black_q;
    total_d = total_q;
    if (start) begin
      busy_d  = 1'b1;
      step_d  = 3'd0;
      guess_d = guess_in;
      sol_d   = sol_in;
      total_d = 3'd0;
    end else if (busy_q) begin
      if (step_q == 3'd0) begin
        black_d = match_cnt;
        step_d  = 3'd1;
      end else begin
        total_d = total_sum[2:0];
        if (step_q == LAST_STEP) busy_d = 1'b0;
        else step_d = step_q + 3'd1;
      end
    end
  end

  // Scorer state registers; reset abandons any scoring in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      step_q  <= 3'd0;
      guess_q <= '0;
      sol_q   <= '0;
      black_q <= 3'd0;
      total_q <= 3'd0;
    end else begin
      busy_q  <= busy_d;
      step_q  <= step_d;
      guess_q <= guess_d;
      sol_q   <= sol_d;
      black_q <= black_d;
      total_q <= total_d;
    end
  end

  assign done  = busy_q && (step_q == LAST_STEP);
  assign black = black_q;
  assign white = 3'(total_sum - {1'b0, black_q});

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game engine driven by a resistive touch panel. Maps raw touch
// coordinates to board cells, debounces presses into single actions, and
// runs the IDLE/PLAY/SCORE/SHOW/WON/LOST game flow.
module mastermind_engine
  import mastermind_pkg::*;
#(
  parameter int NUM_COLS   = 4,
  parameter int NUM_COLORS = 6,
  parameter int NUM_ROWS   = 8,
  parameter int COL_W      = 96,
  parameter int ROW_H      = 100,
  parameter int REARM      = 2500000,
  parameter int HOLD       = 25000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [11:0]           x_coord,
  input  logic [11:0]           y_coord,
  input  logic                  new_coord,
  input  logic                  new_game,
  input  logic                  sol_load,
  input  logic [3*NUM_COLS-1:0] sol_value,
  output logic [3*NUM_COLS-1:0] guess,
  output logic [2:0]            row_index,
  output logic [2:0]            white_pegs,
  output logic [2:0]            black_pegs,
  output logic                  pegs_valid,
  output logic                  started,
  output logic                  game_won,
  output logic                  game_lost,
  output logic [3*NUM_COLS-1:0] solution
);

  localparam int GW     = COLOR_W * NUM_COLS;
  localparam int CNT_W  = $clog2(REARM + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0]  REARM_C    = CNT_W'(REARM);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD - 1);
  localparam logic [2:0]        SUBMIT_COL = 3'(NUM_COLS);
  localparam logic [2:0]        MAX_COLOR  = 3'(NUM_COLORS);
  localparam logic [2:0]        LAST_ROW   = 3'(NUM_ROWS - 1);

  logic [2:0]        state_q, state_d;
  logic [GW-1:0]     guess_q, guess_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        black_q, black_d;
  logic [2:0]        white_q, white_d;
  logic              pegs_valid_q, pegs_valid_d;
  logic              started_q, started_d;
  logic              won_q, won_d;
  logic              lost_q, lost_d;
  logic [GW-1:0]     solution_q, solution_d;
  logic              sol_loaded_q, sol_loaded_d;
  logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       lfsr_q, lfsr_d;

  logic [18:0]       xm, ym;
  logic [9:0]        xp, yp;
  logic [31:0]       row_lo;
  logic              row_hit;
  logic [NUM_COLS:0] col_hit;
  logic [2:0]        col_sel;
  logic              action;
  logic [GW-1:0]     rand_sol;
  logic [NUM_COLS-1:0] field_nz;
  logic              all_set;

  logic              sc_start, sc_done;
  logic [2:0]        sc_black, sc_white;

  // Raw 12-bit panel readings scaled to 480x800 pixels with rounding.
  assign xm = 19'(x_coord) * 19'd15 + 19'd64;
  assign ym = 19'(y_coord) * 19'd25 + 19'd64;
  assign xp = 10'(xm >> 7);
  assign yp = 10'(ym >> 7);

  // Only the active row is touchable; cells are open-below, closed-above.
  assign row_lo  = 32'(row_q) * 32'(ROW_H);
  assign row_hit = (32'(yp) > row_lo) && (32'(yp) <= row_lo + 32'(ROW_H)) &&
                   (32'(yp) <= 32'(SCREEN_H));

  // Column NUM_COLS is the submit button to the right of the pegs.
  genvar gi;
  generate
    for (gi = 0; gi <= NUM_COLS; gi++) begin : g_col_hit
      assign col_hit[gi] = (32'(xp) > 32'(gi * COL_W)) &&
                           (32'(xp) <= 32'((gi + 1) * COL_W)) &&
                           (32'(xp) <= 32'(SCREEN_W));
    end
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_fields
      assign rand_sol[COLOR_W*gi +: COLOR_W] =
        3'((32'(lfsr_q[5*gi+4:5*gi]) % NUM_COLORS) + 1);
      assign field_nz[gi] = |guess_q[COLOR_W*gi +: COLOR_W];
    end
  endgenerate

  assign all_set = &field_nz;

  // Column ranges are disjoint, so at most one bit of col_hit is set.
  always_comb begin
    col_sel = 3'd0;
    for (int c = 0; c <= NUM_COLS; c++) begin
      if (col_hit[c]) col_sel = 3'(c);
    end
  end

  // A press fires only after a full release interval, once per press.
  assign action = new_coord && (rel_cnt_q == REARM_C) && row_hit && (|col_hit);

  mastermind_peg_scorer #(
    .NUM_COLS   (NUM_COLS),
    .NUM_COLORS (NUM_COLORS)
  ) u_scorer (
    .clock    (clock),
    .reset    (reset),
    .start    (sc_start),
    .guess_in (guess_q),
    .sol_in   (solution_q),
    .done     (sc_done),
    .black    (sc_black),
    .white    (sc_white)
  );

  // Game flow, debounce counter and free-running LFSR next-state.
  always_comb begin
    state_d      = state_q;
    guess_d      = guess_q;
    row_d        = row_q;
    black_d      = black_q;
    white_d      = white_q;
    pegs_valid_d = pegs_valid_q;
    started_d    = started_q;
    won_d        = won_q;
    lost_d       = lost_q;
    solution_d   = solution_q;
    sol_loaded_d = sol_loaded_q;
    hold_cnt_d   = hold_cnt_q;
    sc_start     = 1'b0;
    lfsr_d       = lfsr_next(lfsr_q);

    if (new_coord) rel_cnt_d = '0;
    else if (rel_cnt_q != REARM_C) rel_cnt_d = rel_cnt_q + CNT_W'(1);
    else rel_cnt_d = rel_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (sol_load) begin
          solution_d   = sol_value;
          sol_loaded_d = 1'b1;
        end
        // The starting touch only picks the solution; it edits no peg.
        if (action) begin
          if (!sol_load && !sol_loaded_q) solution_d = rand_sol;
          started_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (action) begin
          if (col_sel == SUBMIT_COL) begin
            if (all_set) begin
              sc_start = 1'b1;
              state_d  = ST_SCORE;
            end
          end else begin
            for (int i = 0; i < NUM_COLS; i++) begin
              if (col_sel == 3'(i)) begin
                if (guess_q[COLOR_W*i +: COLOR_W] == MAX_COLOR) guess_d[COLOR_W*i +: COLOR_W] = 3'd1;
                else guess_d[COLOR_W*i +: COLOR_W] = guess_q[COLOR_W*i +: COLOR_W] + 3'd1;
              end
            end
            // Previous row's pegs stay on screen until the player edits.
            pegs_valid_d = 1'b0;
            black_d      = 3'd0;
            white_d      = 3'd0;
          end
        end
      end
      ST_SCORE: begin
        if (sc_done) begin
          black_d      = sc_black;
          white_d      = sc_white;
          pegs_valid_d = 1'b1;
          hold_cnt_d   = '0;
          state_d      = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (black_q == SUBMIT_COL) begin
            won_d   = 1'b1;
            state_d = ST_WON;
          end else if (row_q == 3'd0) begin
            lost_d  = 1'b1;
            state_d = ST_LOST;
          end else begin
            row_d   = row_q - 3'd1;
            guess_d = '0;
            state_d = ST_PLAY;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_WON, ST_LOST: begin
        if (new_game) begin
          guess_d      = '0;
          black_d      = 3'd0;
          white_d      = 3'd0;
          pegs_valid_d = 1'b0;
          won_d        = 1'b0;
          lost_d       = 1'b0;
          started_d    = 1'b0;
          sol_loaded_d = 1'b0;
          row_d        = LAST_ROW;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine registers; reset wins over every other input on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      guess_q      <= '0;
      row_q        <= LAST_ROW;
      black_q      <= 3'd0;
      white_q      <= 3'd0;
      pegs_valid_q <= 1'b0;
      started_q    <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
      solution_q   <= '0;
      sol_loaded_q <= 1'b0;
      rel_cnt_q    <= REARM_C;
      hold_cnt_q   <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      state_q      <= state_d;
      guess_q      <= guess_d;
      row_q        <= row_d;
      black_q      <= black_d;
      white_q      <= white_d;
      pegs_valid_q <= pegs_valid_d;
      started_q    <= started_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
      solution_q   <= solution_d;
      sol_loaded_q <= sol_loaded_d;
      rel_cnt_q    <= rel_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign guess      = guess_q;
  assign row_index  = row_q;
  assign black_pegs = black_q;
  assign white_pegs = white_q;
  assign pegs_valid = pegs_valid_q;
  assign started    = started_q;
  assign game_won   = won_q;
  assign game_lost  = lost_q;
  assign solution   = solution_q;

endmodule

// File: tb/tb_mastermind_engine.sv
// Directed bench for mastermind_engine with REARM=4 and HOLD=8. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_mastermind_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] x_coord = 12'd0;
  logic [11:0] y_coord = 12'd0;
  logic        new_coord = 1'b0;
  logic        new_game = 1'b0;
  logic        sol_load = 1'b0;
  logic [11:0] sol_value = 12'd0;
  logic [11:0] guess;
  logic [2:0]  row_index;
  logic [2:0]  white_pegs;
  logic [2:0]  black_pegs;
  logic        pegs_valid;
  logic        started;
  logic        game_won;
  logic        game_lost;
  logic [11:0] solution;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  mastermind_engine #(
    .NUM_COLS(4), .NUM_COLORS(6), .NUM_ROWS(8), .COL_W(96), .ROW_H(100),
    .REARM(4), .HOLD(8)
  ) dut (
    .clock(clock), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
    .new_coord(new_coord), .new_game(new_game), .sol_load(sol_load),
    .sol_value(sol_value), .guess(guess), .row_index(row_index),
    .white_pegs(white_pegs), .black_pegs(black_pegs), .pegs_valid(pegs_valid),
    .started(started), .game_won(game_won), .game_lost(game_lost),
    .solution(solution)
  );

  // Raw coordinates landing in the centre of column c / row r.
  function automatic logic [11:0] col_x(input int c);
    return 12'(((c * 96 + 48) * 128) / 15);
  endfunction
  function automatic logic [11:0] row_y(input int r);
    return 12'(((r * 100 + 50) * 128) / 25);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [11:0] x, input logic [11:0] y);
    x_coord = x; y_coord = y; new_coord = 1'b1;
    @(negedge clock);
    new_coord = 1'b0;
  endtask

  task automatic touch(input int c, input int r);
    press(col_x(c), row_y(r));
    tick(4);
  endtask

  task automatic enter_guess(input int r, input int n0, input int n1, input int n2, input int n3);
    repeat (n0) touch(0, r);
    repeat (n1) touch(1, r);
    repeat (n2) touch(2, r);
    repeat (n3) touch(3, r);
  endtask

  task automatic pulse_new_game;
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  task automatic load_solution(input logic [11:0] v);
    sol_load = 1'b1; sol_value = v;
    @(negedge clock);
    sol_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    tests_run++; if (guess !== 12'h000) begin tests_failed++; $display("FAIL reset_guess: got %h want 000", guess); end
    tests_run++; if (row_index !== 3'd7) begin tests_failed++; $display("FAIL reset_row: got %0d want 7", row_index); end
    tests_run++; if ({black_pegs, white_pegs, pegs_valid} !== 7'd0) begin tests_failed++; $display("FAIL reset_pegs: got b=%0d w=%0d v=%b want 0", black_pegs, white_pegs, pegs_valid); end
    tests_run++; if ({started, game_won, game_lost} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {started, game_won, game_lost}); end
    tests_run++; if (solution !== 12'h000) begin tests_failed++; $display("FAIL reset_solution: got %h want 000", solution); end
    // Counter comes out of reset re-armed: a press on the very first cycle fires,
    // and the LFSR still holds its seed 35 -> fields 4,2,1,1.
    reset = 1'b0;
    press(col_x(0), row_y(7));
    tests_run++; if (started !== 1'b1) begin tests_failed++; $display("FAIL first_press_start: got %b want 1", started); end
    tests_run++; if (solution !== 12'h254) begin tests_failed++; $display("FAIL lfsr_solution: got %h want 254", solution); end
    tests_run++; if (guess !== 12'h000) begin tests_failed++; $display("FAIL start_no_edit: got %h want 000", guess); end
  endtask

  task automatic test_start;
    reset = 1'b1; tick(1); reset = 1'b0;
    load_solution(12'h8D1);
    touch(0, 7);
    tests_run++; if (started !== 1'b1) begin tests_failed++; $display("FAIL start_started: got %b want 1", started); end
    tests_run++; if (solution !== 12'h8D1) begin tests_failed++; $display("FAIL start_solution: got %h want 8d1", solution); end
    tests_run++; if (guess !== 12'h000) begin tests_failed++; $display("FAIL start_guess: got %h want 000", guess); end
  endtask

  task automatic test_partial_submit;
    press(12'd819, row_y(7)); tick(4);   // xp = 96: top edge of column 0
    tests_run++; if (guess !== 12'h001) begin tests_failed++; $display("FAIL col0_edge: got %h want 001", guess); end
    enter_guess(7, 0, 0, 3, 4);
    tests_run++; if (guess !== 12'h8C1) begin tests_failed++; $display("FAIL partial_guess: got %h want 8c1", guess); end
    touch(4, 7); tick(6);
    tests_run++; if ({guess, pegs_valid} !== {12'h8C1, 1'b0}) begin tests_failed++; $display("FAIL partial_submit_ignored: got %h/%b want 8c1/0", guess, pegs_valid); end
    press(12'd827, row_y(7)); tick(4);   // xp = 97: bottom edge of column 1
    press(12'd827, row_y(7)); tick(4);
    tests_run++; if (guess !== 12'h8D1) begin tests_failed++; $display("FAIL col1_edge: got %h want 8d1", guess); end
    pulse_new_game;
    tests_run++; if ({started, guess} !== {1'b1, 12'h8D1}) begin tests_failed++; $display("FAIL new_game_in_play: got %b/%h want 1/8d1", started, guess); end
  endtask

  task automatic test_win;
    press(col_x(4), row_y(7));
    tick(6);
    tests_run++; if (pegs_valid !== 1'b0) begin tests_failed++; $display("FAIL score_len_early: got %b want 0", pegs_valid); end
    tick(1);
    tests_run++; if (pegs_valid !== 1'b1) begin tests_failed++; $display("FAIL score_len_done: got %b want 1", pegs_valid); end
    tests_run++; if ({black_pegs, white_pegs} !== {3'd4, 3'd0}) begin tests_failed++; $display("FAIL win_pegs: got b=%0d w=%0d want b=4 w=0", black_pegs, white_pegs); end
    tick(7);
    tests_run++; if (game_won !== 1'b0) begin tests_failed++; $display("FAIL show_hold: got %b want 0", game_won); end
    tick(1);
    tests_run++; if (game_won !== 1'b1) begin tests_failed++; $display("FAIL game_won: got %b want 1", game_won); end
    pulse_new_game;
    tests_run++; if ({row_index, game_won, started, pegs_valid, guess} !== {3'd7, 3'b000, 12'h000}) begin tests_failed++; $display("FAIL new_game_after_win: got row=%0d won=%b st=%b v=%b g=%h", row_index, game_won, started, pegs_valid, guess); end
  endtask

  task automatic test_scoring;
    load_solution(12'h489);
    touch(0, 7);
    enter_guess(7, 2, 2, 1, 1);
    tests_run++; if (guess !== 12'h252) begin tests_failed++; $display("FAIL guess_2211: got %h want 252", guess); end
    press(col_x(4), row_y(7)); tick(7);
    tests_run++; if ({pegs_valid, black_pegs, white_pegs} !== {1'b1, 3'd0, 3'd4}) begin tests_failed++; $display("FAIL pegs_2211: got v=%b b=%0d w=%0d want 1 0 4", pegs_valid, black_pegs, white_pegs); end
    tick(8);
    tests_run++; if ({row_index, guess} !== {3'd6, 12'h000}) begin tests_failed++; $display("FAIL next_row6: got %0d/%h want 6/000", row_index, guess); end
    tests_run++; if ({pegs_valid, white_pegs} !== {1'b1, 3'd4}) begin tests_failed++; $display("FAIL pegs_held: got v=%b w=%0d want 1 4", pegs_valid, white_pegs); end
    touch(0, 7);
    tests_run++; if (guess !== 12'h000) begin tests_failed++; $display("FAIL wrong_row_ignored: got %h want 000", guess); end
    touch(0, 6);
    tests_run++; if ({pegs_valid, guess} !== {1'b0, 12'h001}) begin tests_failed++; $display("FAIL first_edit_clears: got %b/%h want 0/001", pegs_valid, guess); end
    enter_guess(6, 0, 2, 2, 1);
    tests_run++; if (guess !== 12'h291) begin tests_failed++; $display("FAIL guess_1221: got %h want 291", guess); end
    press(col_x(4), row_y(6)); tick(7);
    tests_run++; if ({black_pegs, white_pegs} !== {3'd2, 3'd2}) begin tests_failed++; $display("FAIL pegs_1221: got b=%0d w=%0d want 2 2", black_pegs, white_pegs); end
    tick(8);
    tests_run++; if (row_index !== 3'd5) begin tests_failed++; $display("FAIL next_row5: got %0d want 5", row_index); end
  endtask

  task automatic test_lost;
    for (int r = 5; r >= 0; r--) begin
      enter_guess(r, 1, 1, 1, 1);
      press(col_x(4), row_y(r));
      tick(15);
    end
    tests_run++; if ({game_lost, game_won, row_index} !== {2'b10, 3'd0}) begin tests_failed++; $display("FAIL game_lost: got lost=%b won=%b row=%0d want 1 0 0", game_lost, game_won, row_index); end
    tests_run++; if ({black_pegs, white_pegs} !== {3'd2, 3'd0}) begin tests_failed++; $display("FAIL pegs_1111: got b=%0d w=%0d want 2 0", black_pegs, white_pegs); end
    pulse_new_game;
    tests_run++; if ({row_index, game_lost, started} !== {3'd7, 2'b00}) begin tests_failed++; $display("FAIL new_game_after_loss: got row=%0d lost=%b st=%b", row_index, game_lost, started); end
  endtask

  task automatic test_debounce;
    load_solution(12'h8D1);
    touch(0, 7);
    x_coord = col_x(0); y_coord = row_y(7); new_coord = 1'b1;
    tick(100);
    new_coord = 1'b0;
    tests_run++; if (guess[2:0] !== 3'd1) begin tests_failed++; $display("FAIL hold_one_action: got %0d want 1", guess[2:0]); end
    tick(3);
    press(col_x(0), row_y(7));
    tests_run++; if (guess[2:0] !== 3'd1) begin tests_failed++; $display("FAIL short_release: got %0d want 1", guess[2:0]); end
    tick(4);
    press(col_x(0), row_y(7));
    tests_run++; if (guess[2:0] !== 3'd2) begin tests_failed++; $display("FAIL full_release: got %0d want 2", guess[2:0]); end
    tick(4);
  endtask

  task automatic test_wrap;
    repeat (6) touch(1, 7);
    tests_run++; if (guess[5:3] !== 3'd6) begin tests_failed++; $display("FAIL colour_max: got %0d want 6", guess[5:3]); end
    touch(1, 7);
    tests_run++; if (guess[5:3] !== 3'd1) begin tests_failed++; $display("FAIL colour_wrap: got %0d want 1", guess[5:3]); end
    touch(2, 7); touch(3, 7);
    tests_run++; if (guess !== 12'h24A) begin tests_failed++; $display("FAIL guess_2111: got %h want 24a", guess); end
  endtask

  task automatic test_reset_in_score;
    press(col_x(4), row_y(7));
    tick(3);
    reset = 1'b1;
    tick(1);
    tests_run++; if ({guess, row_index} !== {12'h000, 3'd7}) begin tests_failed++; $display("FAIL score_reset_guess_row: got %h/%0d want 000/7", guess, row_index); end
    tests_run++; if ({black_pegs, white_pegs, pegs_valid} !== 7'd0) begin tests_failed++; $display("FAIL score_reset_pegs: got b=%0d w=%0d v=%b", black_pegs, white_pegs, pegs_valid); end
    tests_run++; if ({started, game_won, game_lost, solution} !== 15'd0) begin tests_failed++; $display("FAIL score_reset_flags: got st=%b won=%b lost=%b sol=%h", started, game_won, game_lost, solution); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      tests_run++; if ({pegs_valid, black_pegs, white_pegs, started} !== 8'd0) begin tests_failed++; $display("FAIL stale_after_reset[%0d]: got v=%b b=%0d w=%0d st=%b", i, pegs_valid, black_pegs, white_pegs, started); end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_start;
    test_partial_submit;
    test_win;
    test_scoring;
    test_lost;
    test_debounce;
    test_wrap;
    test_reset_in_score;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
